instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYC, default 255, is the memory-wait limit used only when SEQ_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_o  output  1  instruction fetch request, held until ack.
REQ-006 imem_addr_o  output  16  fetch address, equal to PC.
REQ-007 imem_ack_i  input  1  fetch complete; imem_data_i is valid in the same cycle.
REQ-008 imem_data_i  input  16  instruction word.
REQ-009 dmem_req_o  output  1  data access request, held until ack.
REQ-010 dmem_we_o  output  1  1 = store, 0 = load; valid while dmem_req_o is high.
REQ-011 dmem_ack_i  input  1  data access complete.
REQ-012 flags_i  input  4  ALU flags {V,N,C,Z}.
REQ-013 alu_en_o  output  1  one-cycle ALU execute strobe.
REQ-014 alu_op_o  output  4  ALU function, equal to IR[7:4].
REQ-015 reg_we_o  output  1  one-cycle register-file write strobe.
REQ-016 ir_o  output  16  latched instruction register.
REQ-017 halted_o  output  1  high in HALT state.
REQ-018 fault_o  output  1  high in FAULT state; tied to 0 without SEQ_TIMEOUT_EN.

Function
REQ-019 Instruction fields SHALL be op1=IR[15:14], op2=IR[13:11], cond=IR[10:8], op3=IR[7:4], imm8=IR[7:0].
REQ-020 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT and FAULT; the state after reset SHALL be FETCH.
REQ-021 FETCH SHALL assert imem_req_o and, on imem_ack_i, latch imem_data_i into IR, increment PC by 1 (modulo 2^16, 16'hFFFF wraps to 0), and go to DECODE.
REQ-022 DECODE SHALL branch on op1 as follows:
- 2'b11 (ALU) -> EXEC.
- 2'b00 (load/store) -> MEM only when op2 is 3'b000 or 3'b001; any other op2 -> FETCH as a NOP.
- 2'b10 (branch) -> FETCH; PC <= PC + sign-extended imm8 if the condition holds.
- 2'b01 with op2=3'b111 (HALT) -> HALT; any other op2 -> FETCH.
REQ-023 Condition codes SHALL be: 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 !C, 7 V, each sampled from flags_i in the DECODE cycle.
REQ-024 EXEC SHALL pulse alu_en_o for exactly one cycle, then go to WB.
REQ-025 MEM SHALL assert dmem_req_o with dmem_we_o=(op2==3'b001) until dmem_ack_i; on ack, a load SHALL go to WB and a store SHALL go to FETCH.
REQ-026 WB SHALL pulse reg_we_o for exactly one cycle, then go to FETCH.
REQ-027 Minimum latency SHALL be: ALU instruction 4 cycles, load 4 cycles, store 3 cycles, branch 2 cycles (each counted with a zero-wait ack).
REQ-028 HALT SHALL be terminal; only reset exits it.
REQ-029 An ack arriving while the corresponding request is low SHALL be ignored.
REQ-030 imem_req_o and dmem_req_o SHALL never be high in the same cycle.

Reset
REQ-031 Asserting rst_n low SHALL, asynchronously and at any point mid-operation, force:
- PC = RESET_PC, IR = 0, state = FETCH;
- every output strobe and request = 0;
- halted_o = 0, fault_o = 0.
REQ-032 The first imem_req_o SHALL assert in the first clock cycle after rst_n deasserts.

Configuration
REQ-033 With SEQ_TIMEOUT_EN defined, an 8-bit wait counter SHALL count cycles while in FETCH or MEM without an ack; when it reaches TIMEOUT_CYC, the block SHALL drop the request and enter the terminal FAULT state.
REQ-034 The wait counter SHALL clear on every state change.
REQ-035 Without SEQ_TIMEOUT_EN, there SHALL be no counter, waits SHALL be unbounded, and FAULT SHALL be unreachable.

Structure
REQ-036 The state enum, op1 encodings, cond encodings and the HALT op2 value SHALL live in shared package seq_pkg.
REQ-037 Field extraction and condition evaluation SHALL live in one combinational sub-module, instr_decode.

Verification
REQ-038 Reset mid-MEM (dmem_req_o high) -> all outputs drop immediately; the next cycle after release shows imem_req_o=1 and imem_addr_o=RESET_PC.
REQ-039 Fetch 16'hC350 (ALU, op3=5) with 2-cycle ack delay -> alu_en_o=1 with alu_op_o=4'h5 for one cycle, followed next cycle by reg_we_o=1.
REQ-040 Branch 16'h82FC (cond=2, imm=-4) at PC=0x0010 with Z=0 -> next fetch address 0x000D; repeated with Z=1 -> next fetch address 0x0011.
REQ-041 Store 16'h0800 -> dmem_req_o=1 and dmem_we_o=1 until ack, with no reg_we_o pulse.
REQ-042 Fetch 16'h7800 -> halted_o=1, and no further requests for 100 cycles.
REQ-043 With SEQ_TIMEOUT_EN and imem_ack_i held low -> fault_o=1 after 255 cycles; without the macro -> imem_req_o stays high.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM states,
// opcode-class (op1) values, branch condition codes and the HALT op2 value.
package seq_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StFault
  } seq_state_e;

  localparam logic [1:0] Op1Mem = 2'b00;
  localparam logic [1:0] Op1Sys = 2'b01;
  localparam logic [1:0] Op1Br  = 2'b10;
  localparam logic [1:0] Op1Alu = 2'b11;

  localparam logic [2:0] Op2Load  = 3'b000;
  localparam logic [2:0] Op2Store = 3'b001;
  localparam logic [2:0] Op2Halt  = 3'b111;

  localparam logic [2:0] CondAl = 3'd0;
  localparam logic [2:0] CondZ  = 3'd1;
  localparam logic [2:0] CondNz = 3'd2;
  localparam logic [2:0] CondN  = 3'd3;
  localparam logic [2:0] CondNn = 3'd4;
  localparam logic [2:0] CondC  = 3'd5;
  localparam logic [2:0] CondNc = 3'd6;
  localparam logic [2:0] CondV  = 3'd7;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction for the instruction register plus branch
// condition evaluation against the {V,N,C,Z} flag vector.
module instr_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [3:0]  flags_i,
  output logic [1:0]  op1_o,
  output logic [2:0]  op2_o,
  output logic [3:0]  op3_o,
  output logic        cond_true_o,
  output logic [15:0] br_off_o
);

  logic [2:0] w_cond;
  logic [7:0] w_imm8;
  logic       w_z;
  logic       w_c;
  logic       w_n;
  logic       w_v;

  assign op1_o  = ir_i[15:14];
  assign op2_o  = ir_i[13:11];
  assign w_cond = ir_i[10:8];
  assign op3_o  = ir_i[7:4];
  assign w_imm8 = ir_i[7:0];

  assign w_z = flags_i[0];
  assign w_c = flags_i[1];
  assign w_n = flags_i[2];
  assign w_v = flags_i[3];

  assign br_off_o = {{8{w_imm8[7]}}, w_imm8};

  always_comb begin
    cond_true_o = 1'b0;
    case (w_cond)
      CondAl:  cond_true_o = 1'b1;
      CondZ:   cond_true_o = w_z;
      CondNz:  cond_true_o = ~w_z;
      CondN:   cond_true_o = w_n;
      CondNn:  cond_true_o = ~w_n;
      CondC:   cond_true_o = w_c;
      CondNc:  cond_true_o = ~w_c;
      CondV:   cond_true_o = w_v;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with registered handshakes.
// Optional memory-wait timeout into a terminal FAULT state: SEQ_TIMEOUT_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  input  logic [3:0]  flags_i,
  output logic        alu_en_o,
  output logic [3:0]  alu_op_o,
  output logic        reg_we_o,
  output logic [15:0] ir_o,
  output logic        halted_o,
  output logic        fault_o
);

  seq_state_e  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_alu_en;
  logic        r_reg_we;
  logic        r_halted;

  logic [1:0]  w_op1;
  logic [2:0]  w_op2;
  logic [3:0]  w_op3;
  logic        w_cond_true;
  logic [15:0] w_br_off;

  instr_decode u_decode (
    .ir_i        (r_ir),
    .flags_i     (flags_i),
    .op1_o       (w_op1),
    .op2_o       (w_op2),
    .op3_o       (w_op3),
    .cond_true_o (w_cond_true),
    .br_off_o    (w_br_off)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_wait;
  logic       r_fault;
  assign fault_o = r_fault;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYC;
  assign fault_o = 1'b0;
`endif

  // Outputs are registered: every transition sets up the strobes of the state it enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StFetch;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_alu_en   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_halted   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      r_wait     <= '0;
      r_fault    <= 1'b0;
`endif
    end else begin
`ifdef SEQ_TIMEOUT_EN
      r_wait <= '0;
`endif
      case (r_state)
        StFetch: begin
          // Request is still low only in the first cycle out of reset.
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (imem_ack_i) begin
            r_ir       <= imem_data_i;
            r_pc       <= r_pc + 16'd1;
            r_imem_req <= 1'b0;
            r_state    <= StDecode;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (r_wait == TimeoutLast) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= StFault;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
`endif
        end
        StDecode: begin
          case (w_op1)
            Op1Alu: begin
              r_alu_en <= 1'b1;
              r_state  <= StExec;
            end
            Op1Mem: begin
              if (w_op2 == Op2Load || w_op2 == Op2Store) begin
                r_dmem_req <= 1'b1;
                r_dmem_we  <= (w_op2 == Op2Store);
                r_state    <= StMem;
              end else begin
                r_imem_req <= 1'b1;
                r_state    <= StFetch;
              end
            end
            Op1Br: begin
              if (w_cond_true) r_pc <= r_pc + w_br_off;
              r_imem_req <= 1'b1;
              r_state    <= StFetch;
            end
            Op1Sys: begin
              if (w_op2 == Op2Halt) begin
                r_halted <= 1'b1;
                r_state  <= StHalt;
              end else begin
                r_imem_req <= 1'b1;
                r_state    <= StFetch;
              end
            end
            default: r_state <= StFetch;
          endcase
        end
        StExec: begin
          r_alu_en <= 1'b0;
          r_reg_we <= 1'b1;
          r_state  <= StWb;
        end
        StMem: begin
          if (dmem_ack_i) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_dmem_we) begin
              r_imem_req <= 1'b1;
              r_state    <= StFetch;
            end else begin
              r_reg_we <= 1'b1;
              r_state  <= StWb;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (r_wait == TimeoutLast) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= StFault;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
`endif
        end
        StWb: begin
          r_reg_we   <= 1'b0;
          r_imem_req <= 1'b1;
          r_state    <= StFetch;
        end
        StHalt:  r_state <= StHalt;
        StFault: r_state <= StFault;
        default: r_state <= StFetch;
      endcase
    end
  end

  assign imem_req_o  = r_imem_req;
  assign imem_addr_o = r_pc;
  assign dmem_req_o  = r_dmem_req;
  assign dmem_we_o   = r_dmem_we;
  assign alu_en_o    = r_alu_en;
  assign alu_op_o    = w_op3;
  assign reg_we_o    = r_reg_we;
  assign ir_o        = r_ir;
  assign halted_o    = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, ALU/load/store/branch/NOP/HALT
// flows, PC wrap, and the memory-wait behaviour with or without SEQ_TIMEOUT_EN.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_data_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i;
  logic [3:0]  flags_i;
  logic        alu_en_o;
  logic [3:0]  alu_op_o;
  logic        reg_we_o;
  logic [15:0] ir_o;
  logic        halted_o;
  logic        fault_o;

  int total;
  int bad;

  instr_sequencer #(
    .RESET_PC    (16'h0010),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_ack_i  (dmem_ack_i),
    .flags_i     (flags_i),
    .alu_en_o    (alu_en_o),
    .alu_op_o    (alu_op_o),
    .reg_we_o    (reg_we_o),
    .ir_o        (ir_o),
    .halted_o    (halted_o),
    .fault_o     (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one instruction word with a zero-wait ack; returns in DECODE.
  task automatic fetch(input logic [15:0] word);
    imem_ack_i  = 1'b1;
    imem_data_i = word;
    tick();
    imem_ack_i  = 1'b0;
    imem_data_i = 16'h0000;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    imem_ack_i  = 1'b0;
    imem_data_i = 16'h0000;
    dmem_ack_i  = 1'b0;
    flags_i     = 4'h0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    repeat (2) tick();
    chk("rst_reqs", {imem_req_o, dmem_req_o, dmem_we_o}, 3'b000);
    chk("rst_strobes", {alu_en_o, reg_we_o, halted_o, fault_o}, 4'b0000);
    chk("rst_pc", imem_addr_o, 16'h0010);
    chk("rst_ir", ir_o, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("first_req", {imem_req_o, imem_addr_o}, {1'b1, 16'h0010});

    // ALU 0xC350 with a two-cycle ack delay
    tick();
    chk("alu_wait1", imem_req_o, 1'b1);
    tick();
    chk("alu_wait2", imem_req_o, 1'b1);
    fetch(16'hC350);
    chk("alu_dec", {imem_req_o, ir_o, imem_addr_o}, {1'b0, 16'hC350, 16'h0011});
    tick();
    chk("alu_exec", {alu_en_o, alu_op_o, reg_we_o}, {1'b1, 4'h5, 1'b0});
    tick();
    chk("alu_wb", {alu_en_o, reg_we_o}, 2'b01);
    tick();
    chk("alu_done", {reg_we_o, imem_req_o, imem_addr_o}, {1'b0, 1'b1, 16'h0011});

    // Store 0x0800 with one wait cycle on the data port
    fetch(16'h0800);
    chk("st_dec", dmem_req_o, 1'b0);
    tick();
    chk("st_mem", {dmem_req_o, dmem_we_o, imem_req_o}, 3'b110);
    tick();
    chk("st_hold", {dmem_req_o, dmem_we_o, reg_we_o}, 3'b110);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("st_done", {dmem_req_o, reg_we_o, imem_req_o, imem_addr_o}, {3'b001, 16'h0012});

    // Load 0x0000
    fetch(16'h0000);
    tick();
    chk("ld_mem", {dmem_req_o, dmem_we_o}, 2'b10);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("ld_wb", {reg_we_o, dmem_req_o, imem_req_o}, 3'b100);
    tick();
    chk("ld_done", {reg_we_o, imem_req_o, imem_addr_o}, {2'b01, 16'h0013});

    // Data ack while no data request is outstanding must be ignored
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("stray_ack", {imem_req_o, dmem_req_o, imem_addr_o}, {2'b10, 16'h0013});

    // Asynchronous reset in the middle of a store
    fetch(16'h0800);
    tick();
    chk("mid_mem", dmem_req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_reqs", {dmem_req_o, dmem_we_o, imem_req_o, reg_we_o}, 4'b0000);
    chk("arst_state", {imem_addr_o, ir_o}, {16'h0010, 16'h0000});
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_restart", {imem_req_o, imem_addr_o}, {1'b1, 16'h0010});

    // Branch 0x82FC (cond !Z, imm -4) taken with Z=0
    flags_i = 4'b0000;
    fetch(16'h82FC);
    tick();
    chk("br_nz_taken", {imem_req_o, imem_addr_o}, {1'b1, 16'h000D});

    // Same branch from 0x0010 with Z=1: not taken
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    flags_i = 4'b0001;
    fetch(16'h82FC);
    tick();
    chk("br_nz_fall", {imem_req_o, imem_addr_o}, {1'b1, 16'h0011});
    flags_i = 4'b0000;

    fetch(16'h8005);
    tick();
    chk("br_always", imem_addr_o, 16'h0017);
    flags_i = 4'b0100;
    fetch(16'h83F0);
    tick();
    chk("br_n_taken", imem_addr_o, 16'h0008);
    flags_i = 4'b0000;
    fetch(16'h80F0);
    tick();
    chk("br_wrap_back", imem_addr_o, 16'hFFF9);
    fetch(16'h8005);
    tick();
    chk("br_to_ffff", imem_addr_o, 16'hFFFF);

    // NOP (op1=00, op2=010) at 0xFFFF: PC increment wraps to zero
    fetch(16'h1000);
    chk("pc_wrap", {imem_addr_o, dmem_req_o}, {16'h0000, 1'b0});
    tick();
    chk("nop_done", {imem_req_o, dmem_req_o, imem_addr_o}, {2'b10, 16'h0000});

    // HALT is terminal even with acks held high
    fetch(16'h7800);
    tick();
    chk("halt_enter", {halted_o, imem_req_o, dmem_req_o}, 3'b100);
    imem_ack_i = 1'b1;
    dmem_ack_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("halt_quiet", {imem_req_o, dmem_req_o, halted_o}, 3'b001);
    end
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;

    // Fetch with no ack at all
    rst_n = 1'b0;
    tick();
    chk("halt_cleared", halted_o, 1'b0);
    rst_n = 1'b1;
    tick();
`ifdef SEQ_TIMEOUT_EN
    repeat (254) tick();
    chk("to_before", {fault_o, imem_req_o}, 2'b01);
    tick();
    chk("to_fault", {fault_o, imem_req_o}, 2'b10);
`else
    repeat (300) tick();
    chk("no_timeout", {fault_o, imem_req_o, imem_addr_o}, {2'b01, 16'h0010});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
